// File: rtl/ibex_multdiv_seq_if.sv
// Request, response and multdiv-side signals of the sequencing wrapper.
// The master modport drives the *_i signals (ID stage, writeback, multdiv).
// The slave modport is the sequencer, which drives the *_o signals.
interface ibex_multdiv_seq_if;
    // ID-stage request
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_operator_i;
    logic [1:0]  req_signed_mode_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic        flush_i;
    logic        data_ind_timing_i;

    // Towards the multiplier/divider
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic        md_mult_sel_o;
    logic        md_div_sel_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic        md_ready_id_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;

    // Writeback response
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_hit_o;

    modport master (
        output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
        output flush_i, data_ind_timing_i, md_valid_i, md_result_i, rsp_ready_i,
        input  req_ready_o, md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
        input  md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o,
        input  rsp_valid_o, rsp_result_o, rsp_hit_o
    );

    modport slave (
        input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
        input  flush_i, data_ind_timing_i, md_valid_i, md_result_i, rsp_ready_i,
        output req_ready_o, md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o,
        output md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_id_o,
        output rsp_valid_o, rsp_result_o, rsp_hit_o
    );
endinterface

// File: rtl/ibex_multdiv_seq.sv
// Sequencer in front of the Ibex multiplier/divider: latches one request,
// runs the multdiv (or answers from a one-entry result cache), handles
// pipeline flushes while the multdiv is busy, and holds the response until
// writeback takes it.
module ibex_multdiv_seq #(
    parameter bit CacheEn = 1'b1
) (
    input logic               clk_i,
    input logic               rst_ni,
    ibex_multdiv_seq_if.slave bus
);

    // Same encoding as ibex_pkg::md_op_e.
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    // The four request fields; also the cache tag.
    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } md_req_t;

    state_e      state_q, state_d;
    md_req_t     req_q, req_d;
    md_req_t     req_in;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_hit_q, rsp_hit_d;

    logic        accept;
    logic        cache_hit;
    logic        cache_we;
    logic [31:0] cache_result;
    logic        md_active;
    logic        op_is_mult;
    logic        op_is_div;

    assign req_in = '{op:          bus.req_operator_i,
                      signed_mode: bus.req_signed_mode_i,
                      op_a:        bus.req_op_a_i,
                      op_b:        bus.req_op_b_i};

    assign accept = bus.req_valid_i & (state_q == IDLE) & ~bus.flush_i;

    // One-entry result cache, only present when enabled.
    if (CacheEn) begin : g_cache
        md_req_t     cache_tag_q;
        logic [31:0] cache_result_q;
        logic        cache_valid_q;

        // Cache write on every completed multdiv run (including dropped ones).
        // NOTE: the tag/data registers are reset as well as the valid bit; with a
        // single entry the cost is small and the outputs stay free of X after reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cache_tag_q    <= '0;
                cache_result_q <= '0;
                cache_valid_q  <= 1'b0;
            end else if (cache_we) begin
                cache_tag_q    <= req_q;
                cache_result_q <= bus.md_result_i;
                cache_valid_q  <= 1'b1;
            end
        end

        assign cache_hit    = ~bus.data_ind_timing_i & cache_valid_q & (cache_tag_q == req_in);
        assign cache_result = cache_result_q;
    end else begin : g_no_cache
        assign cache_hit    = 1'b0;
        assign cache_result = '0;
    end

    // Next-state logic for the sequencer and its datapath registers.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rsp_result_d = rsp_result_q;
        rsp_hit_d    = rsp_hit_q;
        cache_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d = req_in;
                    if (cache_hit) begin
                        rsp_result_d = cache_result;
                        rsp_hit_d    = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.md_valid_i) begin
                    // The multdiv result is valid regardless of a flush, so cache it.
                    cache_we = 1'b1;
                    if (bus.flush_i) begin
                        state_d = IDLE;
                    end else begin
                        rsp_result_d = bus.md_result_i;
                        rsp_hit_d    = 1'b0;
                        state_d      = RESP;
                    end
                end else if (bus.flush_i) begin
                    // The multdiv cannot be aborted; keep it enabled until it finishes.
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.md_valid_i) begin
                    cache_we = 1'b1;
                    state_d  = IDLE;
                end
            end
            RESP: begin
                if (bus.flush_i || bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_q        <= '0;
            rsp_result_q <= '0;
            rsp_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rsp_result_q <= rsp_result_d;
            rsp_hit_q    <= rsp_hit_d;
        end
    end

    assign md_active  = (state_q == BUSY) || (state_q == DRAIN);
    assign op_is_mult = (req_q.op == MD_OP_MULL) || (req_q.op == MD_OP_MULH);
    assign op_is_div  = (req_q.op == MD_OP_DIV)  || (req_q.op == MD_OP_REM);

    assign bus.req_ready_o      = (state_q == IDLE);
    assign bus.md_mult_en_o     = md_active & op_is_mult;
    assign bus.md_mult_sel_o    = md_active & op_is_mult;
    assign bus.md_div_en_o      = md_active & op_is_div;
    assign bus.md_div_sel_o     = md_active & op_is_div;
    assign bus.md_ready_id_o    = md_active;
    assign bus.md_operator_o    = req_q.op;
    assign bus.md_signed_mode_o = req_q.signed_mode;
    assign bus.md_op_a_o        = req_q.op_a;
    assign bus.md_op_b_o        = req_q.op_b;
    assign bus.rsp_valid_o      = (state_q == RESP);
    assign bus.rsp_result_o     = rsp_result_q;
    assign bus.rsp_hit_o        = rsp_hit_q;

endmodule

// File: doc/ibex_multdiv_seq.md
IBEX_MULTDIV_SEQ -- requirements
Module: ibex_multdiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i (rising edge) and rst_ni (asynchronous assert, active low).
REQ-002 Parameter CacheEn, default 1'b1: enables the one-entry result cache.
REQ-003 Ports SHALL be, as name direction width meaning:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  1  ID-stage request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_operator_i  in  2  ibex_pkg::md_op_e (MULL/MULH/DIV/REM)
- req_signed_mode_i  in  2  bit0 = A signed, bit1 = B signed
- req_op_a_i, req_op_b_i  in  32 each  operands
- flush_i  in  1  pipeline kill
- data_ind_timing_i  in  1  data-independent timing; disables cache hits
- md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o  out  1 each  multdiv enables/selects
- md_operator_o  out  2  latched operator
- md_signed_mode_o  out  2  latched signed mode
- md_op_a_o, md_op_b_o  out  32 each  latched operands
- md_ready_id_o  out  1  consumer ready to multdiv
- md_valid_i  in  1  multdiv result valid
- md_result_i  in  32  multdiv result
- rsp_valid_o  out  1  result valid to writeback
- rsp_ready_i  in  1  writeback accepts
- rsp_result_o  out  32  result
- rsp_hit_o  out  1  result came from cache

Function
REQ-004 FSM states SHALL be IDLE, BUSY, DRAIN, RESP; reset state IDLE.
REQ-005 req_ready_o SHALL be 1 only in IDLE; acceptance = req_valid_i & req_ready_o & ~flush_i.
REQ-006 On acceptance, operator, signed mode, op_a, op_b SHALL be latched into md_* registers, which SHALL stay constant until the FSM returns to IDLE.
REQ-007 Cache hit on acceptance = CacheEn & ~data_ind_timing_i & cache_valid & all four request fields equal the cache tag; hit -> RESP with cached result, rsp_hit_o=1, multdiv not enabled.
REQ-008 Miss on acceptance -> BUSY.
REQ-009 In BUSY and DRAIN: md_mult_en_o = md_mult_sel_o = (op is MULL or MULH); md_div_en_o = md_div_sel_o = (op is DIV or REM); md_ready_id_o = 1. All four SHALL be 0 in IDLE and RESP.
REQ-010 BUSY, md_valid_i=1: capture md_result_i into rsp_result_o, rsp_hit_o=0, write cache (tag = latched fields, valid=1), -> RESP.
REQ-011 BUSY, flush_i=1 and md_valid_i=0: -> DRAIN (multdiv has no abort; enables stay asserted so its FSM returns to idle).
REQ-012 BUSY, flush_i=1 and md_valid_i=1 same cycle: result discarded, cache still written, -> IDLE.
REQ-013 DRAIN: req_ready_o=0, rsp_valid_o=0; on md_valid_i, write cache, -> IDLE; flush_i ignored.
REQ-014 RESP: rsp_valid_o=1, rsp_result_o/rsp_hit_o stable; rsp_ready_i=1 -> IDLE; flush_i=1 -> IDLE with response dropped (flush wins over rsp_ready_i).
REQ-015 Latency: miss, rsp_valid_o rises the cycle after md_valid_i; hit, rsp_valid_o rises the cycle after acceptance. Throughput: one request per response plus one IDLE cycle.
REQ-016 CacheEn=0 SHALL force hits to 0 and make cache registers unused.

Reset
REQ-017 On rst_ni low: state IDLE, req_ready_o=1, all md_* outputs 0, rsp_valid_o=0, rsp_result_o=0, rsp_hit_o=0, cache_valid=0.
REQ-018 Reset mid-operation SHALL abandon the operation; no response issued; multdiv is reset by the same rst_ni.

Verification
REQ-019 MULL, A=7, B=6, unsigned -> md_mult_en_o high until md_valid_i; rsp_result_o=42, rsp_hit_o=0.
REQ-020 Repeat MULL 7x6, data_ind_timing_i=0 -> RESP next cycle, rsp_result_o=42, rsp_hit_o=1, md_mult_en_o never high; same with data_ind_timing_i=1 -> miss, full multdiv run.
REQ-021 DIV signed, A=-7, B=2, flush_i pulsed 3 cycles after accept -> DRAIN, md_div_en_o held until md_valid_i, no rsp_valid_o; next DIV 20/3 -> rsp_result_o=6.
REQ-022 REM A=5, B=0 -> rsp_result_o=5; DIV A=5, B=0 -> 0xFFFFFFFF.
REQ-023 RESP with rsp_ready_i=0 for 4 cycles -> rsp_valid_o and rsp_result_o stable, req_ready_o=0; then rsp_ready_i=1 -> IDLE next cycle.
REQ-024 rst_ni asserted in BUSY -> all outputs at REQ-017 values immediately; next identical request is a miss.
